sdes_rx_deserializer: RTL

// - Receive-side deserializer for the SerDes link: turns the 1-bit serial stream from the TX serializer back into 32-bit words.
// - Hunts for a sync word, verifies it over several consecutive words, then locks word alignment.
// - Once locked, emits one parallel word with a valid strobe every WIDTH cycles.
// - Sits between the serial channel and the parallel data_out of the SerDes top.

---
 rtl/sdes_pkg.sv | 10 +
 rtl/sdes_rx_shifter.sv | 27 ++
 rtl/sdes_rx_deserializer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sdes_pkg.sv
// Shared SerDes definitions: RX FSM state encoding plus the word width and
// alignment word used by both the TX serializer and the RX deserializer.
package sdes_pkg;

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} sdes_rx_state_e;

    localparam int          SDES_WIDTH     = 32;
    localparam logic [31:0] SDES_SYNC_WORD = 32'hF0C3_5A96;

endpackage

// File: rtl/sdes_rx_shifter.sv
// Serial-in shift register with a sync-word comparator on the post-shift value,
// so the FSM sees the word that completes on this edge.
module sdes_rx_shifter #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] SYNC_WORD = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    output logic [WIDTH-1:0] nxt,
    output logic             sync_hit
);

    logic [WIDTH-1:0] shreg_q, shreg_d;

    always_comb begin
        shreg_d  = {shreg_q[WIDTH-2:0], serial_in};
        nxt      = shreg_d;
        sync_hit = (shreg_d == SYNC_WORD);
    end

    always_ff @(posedge clk) begin
        if (rst) shreg_q <= '0;
        else     shreg_q <= shreg_d;
    end

endmodule

// File: rtl/sdes_rx_deserializer.sv
// RX deserializer: hunts for SYNC_WORD, verifies LOCK_CNT aligned copies, then
// emits one word per WIDTH cycles. Define SDES_RX_ERRCNT_EN to add err_cnt.
module sdes_rx_deserializer
    import sdes_pkg::*;
#(
    parameter int               WIDTH     = SDES_WIDTH,
    parameter logic [WIDTH-1:0] SYNC_WORD = SDES_SYNC_WORD,
    parameter int               LOCK_CNT  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             realign,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             locked
`ifdef SDES_RX_ERRCNT_EN
    ,
    output logic [15:0]      err_cnt
`endif
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [3:0]    LOCK_N   = 4'(LOCK_CNT);

    sdes_rx_state_e   state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             locked_q, locked_d;
    logic [WIDTH-1:0] nxt;
    logic             sync_hit;
    logic             wrap;

    sdes_rx_shifter #(
        .WIDTH     (WIDTH),
        .SYNC_WORD (SYNC_WORD)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .nxt       (nxt),
        .sync_hit  (sync_hit)
    );

    assign wrap = (bit_cnt_q == LAST_BIT);

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = wrap ? '0 : bit_cnt_q + CW'(1);
        match_cnt_d  = match_cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;

        if (realign) begin
            // Drop lock immediately; a word completing this edge is discarded.
            state_d     = HUNT;
            bit_cnt_d   = '0;
            match_cnt_d = '0;
        end else begin
            unique case (state_q)
                HUNT: begin
                    bit_cnt_d = '0;
                    if (sync_hit) begin
                        match_cnt_d = 4'd1;
                        state_d     = (LOCK_CNT == 1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    if (wrap) begin
                        if (sync_hit) begin
                            match_cnt_d = match_cnt_q + 4'd1;
                            if (match_cnt_d == LOCK_N) state_d = LOCKED;
                        end else begin
                            state_d     = HUNT;
                            match_cnt_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (wrap) begin
                        data_out_d   = nxt;
                        data_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d     = HUNT;
                    bit_cnt_d   = '0;
                    match_cnt_d = '0;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            bit_cnt_q    <= '0;
            match_cnt_q  <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            match_cnt_q  <= match_cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            locked_q     <= locked_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign locked     = locked_q;

`ifdef SDES_RX_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        err_inc;

    always_comb begin
        err_inc   = (state_q == VERIFY && wrap && !sync_hit) ||
                    (state_q == LOCKED && realign);
        err_cnt_d = (err_inc && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
